// File: rtl/spectrum_mem_map.sv
// Spectrum CPU clock divider and 128K-style memory map controller.
// Optional feature: define CONTENTION_EN to add the contend port and divider stall.
module spectrum_mem_map #(
  parameter int CLK_DIV       = 3,
  parameter int CLK_LOW       = 1,
  parameter int BANK_BITS     = 3,
  parameter int ROM_PAGE_BITS = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  output logic                          cpu_clk,
  output logic                          cpu_clk_rise,
  input  logic [15:0]                   cpu_addr,
  input  logic [7:0]                    cpu_dout,
  input  logic                          n_mreq,
  input  logic                          n_iorq,
  input  logic                          n_rd,
  input  logic                          n_wr,
  input  logic [7:0]                    rom_dout,
  input  logic [7:0]                    ram_dout,
`ifdef CONTENTION_EN
  input  logic                          contend,
`endif
  output logic [14+ROM_PAGE_BITS-1:0]   rom_addr,
  output logic [14+BANK_BITS-1:0]       ram_addr,
  output logic                          ram_we,
  output logic [7:0]                    cpu_din,
  output logic                          screen_page,
  output logic                          page_locked
);

  localparam logic [5:0] LAST = 6'(CLK_DIV - 1);
  localparam logic [5:0] LOW  = 6'(CLK_LOW);

  logic [5:0] count;
  logic [5:0] next_count;
  logic       hold;
  logic [7:0] page_q;
  logic       memwr_d;
  logic       iowr_d;
  logic [1:0] seg;
  logic [2:0] bank_full;
  logic       memwr;
  logic       port_wr;
  logic       unused_bits;

  assign seg = cpu_addr[15:14];

  always_comb begin
    case (seg)
      2'b01:   bank_full = 3'd5;
      2'b10:   bank_full = 3'd2;
      2'b11:   bank_full = page_q[2:0];
      default: bank_full = 3'd0;
    endcase
  end

  // Divider stalls only at the last high-phase count so cpu_clk is held high.
  always_comb begin
    hold = 1'b0;
`ifdef CONTENTION_EN
    hold = contend && !n_mreq && (seg == 2'b01 || (seg == 2'b11 && bank_full[0]))
           && cpu_clk && (count == LAST);
`endif
    if (hold)
      next_count = count;
    else if (count == LAST)
      next_count = 6'd0;
    else
      next_count = count + 6'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= 6'd0;
      cpu_clk      <= 1'b0;
      cpu_clk_rise <= 1'b0;
    end else begin
      count        <= next_count;
      cpu_clk      <= (next_count >= LOW);
      cpu_clk_rise <= !cpu_clk && (next_count >= LOW);
    end
  end

  assign memwr   = !n_mreq && !n_wr && (seg != 2'b00);
  assign port_wr = !n_iorq && !n_wr && !cpu_addr[15] && !cpu_addr[1];

  // Both strobes are edge-detected so a held strobe acts exactly once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      memwr_d <= 1'b0;
      iowr_d  <= 1'b0;
      ram_we  <= 1'b0;
      page_q  <= 8'h00;
    end else begin
      memwr_d <= memwr;
      iowr_d  <= port_wr;
      ram_we  <= memwr && !memwr_d;
      if (port_wr && !iowr_d && !page_q[5])
        page_q <= {2'b00, cpu_dout[5:0]};
    end
  end

  generate
    if (ROM_PAGE_BITS == 1) begin : g_rom_paged
      assign rom_addr = {page_q[4], cpu_addr[13:0]};
    end else begin : g_rom_flat
      assign rom_addr = cpu_addr[13:0];
    end
  endgenerate

  assign ram_addr = {bank_full[BANK_BITS-1:0], cpu_addr[13:0]};

  always_comb begin
    cpu_din = 8'hFF;
    if (!n_mreq && !n_rd)
      cpu_din = (seg == 2'b00) ? rom_dout : ram_dout;
  end

  assign screen_page = page_q[3];
  assign page_locked = page_q[5];

  assign unused_bits = &{1'b0, cpu_dout[7:6], page_q, bank_full};

endmodule
